// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator/checker pair.
// Holds the search FSM state type and an index-sizing helper.
// Pure declarations; no logic, no timing, no flow control.
package fib_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } fib_state_t;

    // Largest k such that F(k) < 2**width. Evaluated at elaboration time to
    // size and sanity-check index ports (47 for width 32). Valid to width 126.
    function automatic int fib_max_index(input int width);
        logic [127:0] fa;
        logic [127:0] fb;
        logic [127:0] ft;
        logic [127:0] limit;
        int           k;
        fa    = '0;
        fb    = 128'd1;
        k     = 0;
        limit = 128'd1 << width;
        // fb is F(k+1); advance while the next term still fits in width bits
        for (int i = 0; i < 200; i++) begin
            if (fb < limit) begin
                ft = fa + fb;
                fa = fb;
                fb = ft;
                k  = k + 1;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/fib_index.sv
// Fibonacci index finder: reports whether value is F(k) and its (floor) index k.
// Latency: k+1 cycles on a match at k, j+2 cycles for a non-member with floor index j.
// Backpressure: start is accepted only while busy=0; start/value are ignored while busy.
module fib_index
    import fib_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             is_fib,
    output logic [IDX_W-1:0] index
);

    // The index output must be able to hold the largest reachable index.
    if (IDX_W < $clog2(fib_max_index(WIDTH) + 1)) begin : g_idx_w_check
        $error("fib_index: IDX_W too small for WIDTH");
    end

    fib_state_t       state;
    // One extra bit keeps the first term above any WIDTH-bit target exact,
    // so the search stops before truncation can ever matter.
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   b;
    logic [IDX_W-1:0] k;
    logic [WIDTH-1:0] target;

    logic             hit_eq;
    logic             hit_gt;

    // Compare the current term F(k) against the zero-extended target.
    assign hit_eq = (a == {1'b0, target});
    assign hit_gt = (a >  {1'b0, target});

    // Search FSM and datapath: capture on start, step F(k) until it reaches the target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            is_fib <= 1'b0;
            index  <= '0;
            a      <= '0;
            b      <= (WIDTH+1)'(1);
            k      <= '0;
            target <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        target <= value;
                        a      <= '0;
                        b      <= (WIDTH+1)'(1);
                        k      <= '0;
                        busy   <= 1'b1;
                        state  <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (hit_eq) begin
                        is_fib <= 1'b1;
                        index  <= k;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (hit_gt) begin
                        // k is at least 1 here because F(0)=0 never exceeds a target
                        is_fib <= 1'b0;
                        index  <= k - IDX_W'(1);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        a <= b;
                        b <= a + b;
                        k <= k + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_index.sv
// Self-checking bench for fib_index (WIDTH=32, IDX_W=8).
// Reference model: a precomputed Fibonacci table searched with plain arithmetic.
// Directed cases, mid-search reset, start hammering, table sweep and random values.
module tb_fib_index;

    localparam int WIDTH = 32;
    localparam int IDX_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic             is_fib;
    logic [IDX_W-1:0] index;

    int errors;
    int checks;

    longint unsigned fib_tab [0:49];

    // Result the outputs must be holding between operations
    logic             exp_fib;
    logic [IDX_W-1:0] exp_idx;

    fib_index #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .value  (value),
        .busy   (busy),
        .done   (done),
        .is_fib (is_fib),
        .index  (index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: smallest k with F(k)==v, else largest k with F(k)<v
    task automatic model(input longint unsigned v, output logic isf,
                         output int idx, output int lat);
        isf = 1'b0;
        idx = 0;
        lat = 0;
        for (int i = 49; i >= 0; i--) begin
            if (fib_tab[i] == v) begin
                isf = 1'b1;
                idx = i;
            end
        end
        if (isf) begin
            lat = idx + 1;
        end else begin
            for (int i = 0; i < 50; i++)
                if (fib_tab[i] < v) idx = i;
            lat = idx + 2;
        end
    endtask

    // Present start at a falling edge; the next rising edge accepts it
    task automatic start_op(input logic [WIDTH-1:0] v);
        @(negedge clk);
        start = 1'b1;
        value = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("done_low_after_accept", done, 0);
    endtask

    // Wait for done, checking held outputs meanwhile; compare result and latency
    task automatic wait_done(input logic isf, input int idx, input int lat, input bit hammer);
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (hammer) begin
                start = 1'b1;
                value = $urandom;
            end
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                seen = 1;
                break;
            end
            chk("hold_is_fib", is_fib, exp_fib);
            chk("hold_index", index, exp_idx);
        end
        chk("done_seen", seen, 1);
        chk("latency", n, lat);
        chk("busy_at_done", busy, 0);
        chk("is_fib", is_fib, isf);
        chk("index", index, idx);
        exp_fib = isf;
        exp_idx = IDX_W'(idx);
    endtask

    task automatic run_model(input logic [WIDTH-1:0] v, input bit hammer);
        logic isf;
        int   idx;
        int   lat;
        model(longint'(v), isf, idx, lat);
        start_op(v);
        wait_done(isf, idx, lat, hammer);
    endtask

    // Directed expectations written out by hand
    logic [WIDTH-1:0] d_val [0:6];
    logic             d_fib [0:6];
    int               d_idx [0:6];
    int               d_lat [0:6];

    initial begin
        errors  = 0;
        checks  = 0;
        exp_fib = 1'b0;
        exp_idx = '0;
        start   = 1'b0;
        value   = '0;
        rst     = 1'b0;

        fib_tab[0] = 0;
        fib_tab[1] = 1;
        for (int i = 2; i < 50; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];

        d_val[0] = 32'd0;          d_fib[0] = 1; d_idx[0] = 0;  d_lat[0] = 1;
        d_val[1] = 32'd1;          d_fib[1] = 1; d_idx[1] = 1;  d_lat[1] = 2;
        d_val[2] = 32'd2;          d_fib[2] = 1; d_idx[2] = 3;  d_lat[2] = 4;
        d_val[3] = 32'd4;          d_fib[3] = 0; d_idx[3] = 4;  d_lat[3] = 6;
        d_val[4] = 32'd100;        d_fib[4] = 0; d_idx[4] = 11; d_lat[4] = 13;
        d_val[5] = 32'd2971215073; d_fib[5] = 1; d_idx[5] = 47; d_lat[5] = 48;
        d_val[6] = 32'hFFFFFFFF;   d_fib[6] = 0; d_idx[6] = 47; d_lat[6] = 49;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_is_fib", is_fib, 0);
        chk("rst_index", index, 0);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases with hand-derived results
        for (int i = 0; i < 7; i++) begin
            start_op(d_val[i]);
            wait_done(d_fib[i], d_idx[i], d_lat[i], 1'b0);
        end

        // Reset during a search: outputs clear at once and no done follows
        start_op(32'd1000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_is_fib", is_fib, 0);
        chk("midrst_index", index, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("midrst_no_done", done, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_fib = 1'b0;
        exp_idx = '0;
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("postrst_no_done", done, 0);
        end
        start_op(32'd8);
        wait_done(1'b1, 6, 7, 1'b0);

        // Start hammered with changing value while busy; then accepted in the done cycle
        run_model(32'd1000, 1'b1);
        run_model(32'd233, 1'b1);
        run_model(32'd50, 1'b0);

        // Every table entry must map back to its own index (F(2)=1 gives index 1)
        for (int n = 0; n <= 47; n++) begin
            start_op(fib_tab[n][WIDTH-1:0]);
            wait_done(1'b1, (n == 2) ? 1 : n, (n == 2) ? 2 : n + 1, 1'b0);
        end

        // Random values across magnitudes, including neighbours of table entries
        for (int r = 0; r < 40; r++) begin
            logic [WIDTH-1:0] v;
            if (r % 4 == 0) begin
                logic [63:0] f;
                f = fib_tab[$urandom_range(3, 47)];
                v = f[WIDTH-1:0] + WIDTH'($urandom_range(0, 2)) - WIDTH'(1);
            end else begin
                v = $urandom >> $urandom_range(0, 31);
            end
            run_model(v, r[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
